bram_pipe_ctrl: RTL and testbench
=================================

# bram_pipe_ctrl

Parametrised fixed-latency BRAM controller sitting behind the memory arbiter, serving N requesters (DMA, CPU cache, and future masters) from one on-chip word-addressed memory. Every accepted request emerges exactly LAT cycles later as a response routed to the originating channel. Byte-write strobes, per-channel write acknowledges and an in-flight counter extend the single-DMA/single-CPU controller. Accepts one request per cycle with no back-pressure.

## Interface
- AW, 13, word address width; memory depth 2^AW words
- DW, 32, data width; must be a multiple of 8
- LAT, 10, request-to-response latency in cycles; legal range 2..32
- NCH, 2, number of requester channels (ch 0 = DMA, ch 1 = CPU cache by convention); legal range 1..8
- CW, max(1,clog2(NCH)), channel-id width (derived)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  word address
- req_wdata  in  DW  write data
- req_wstrb  in  DW/8  byte enables for writes; ignored on reads
- req_ch  in  CW  originating channel id
- rsp_valid  out  NCH  one-hot; bit c = response for channel c this cycle
- rsp_we  out  1  response is a write acknowledge (1) or read data (0)
- rsp_rdata  out  DW  read data; meaningful only when rsp_valid != 0 and rsp_we = 0
- rsp_err  out  1  pulse: request with req_ch >= NCH reached its response slot
- inflight  out  clog2(LAT+1)  number of accepted requests not yet responded

## Operation
- Request accepted on every rising edge where req_valid = 1; no ready signal, the arbiter guarantees at most one request per cycle.
- Accepted request fields (we, addr, wdata, wstrb, ch) enter a LAT-stage shift pipeline; stage valids cleared by rst.
- Memory access occurs at stage LAT-1: write updates only bytes with wstrb = 1; read samples the array.
- Accesses execute strictly in acceptance order: a read accepted one or more cycles after a write to the same address returns the written bytes; unwritten bytes keep old value.
- Write with wstrb = 0 performs no array update but still produces an acknowledge.
- Response: rsp_valid[ch] = 1 for one cycle, rsp_we = request's we. Reads and writes both respond.
- req_ch >= NCH: no array access, rsp_valid stays 0, rsp_err = 1 in the response cycle.
- inflight: +1 on accept, -1 on response (including error slot); simultaneous accept and response leave it unchanged. Never exceeds LAT.
- Memory array not reset; contents undefined until written.

## Timing
- Request sampled at edge E0 -> rsp_valid/rsp_we/rsp_rdata/rsp_err valid in the cycle following edge E(LAT), i.e. exactly LAT cycles after the request cycle. Fully pipelined: back-to-back requests give back-to-back responses.
- rsp_valid, rsp_we, rsp_err are registered; rsp_rdata registered, holds last read value when no read response.
- inflight is registered and reflects accepts/responses from the previous edge.
- Reset values: rsp_valid = 0, rsp_we = 0, rsp_rdata = 0, rsp_err = 0, inflight = 0.
- rst asserted mid-operation: all in-flight requests discarded, no responses for them after rst deasserts, pending writes at stages < LAT-1 not performed; the first request after release responds LAT cycles later.

## Test plan
- Write 0xDEADBEEF to addr 0x005 (ch 0, wstrb 0xF), then read addr 0x005 (ch 1) next cycle -> rsp_valid = 2'b01, rsp_we = 1 at cycle 10; rsp_valid = 2'b10, rsp_rdata = 0xDEADBEEF at cycle 11.
- Partial write 0x000000AA with wstrb 0x1 over 0x11223344 at addr 0x1FFF -> subsequent read returns 0x112233AA; write with wstrb 0x0 then read -> value unchanged, write ack still issued.
- Streaming: 20 consecutive reads on alternating channels over preloaded addresses -> 20 consecutive responses, correct data and one-hot routing, inflight saturates at 10 and returns to 0.
- Request with req_ch = 3 (NCH = 2, CW = 1 instantiated with NCH = 3 for this case, ch = 3 not valid) -> rsp_err pulse at cycle LAT, no rsp_valid bit, memory unchanged.
- Issue 5 writes then assert rst 3 cycles later -> no responses after release, inflight = 0, targeted addresses not modified by discarded writes.
- Re-run first scenario with LAT = 2, NCH = 4, DW = 64 -> responses at cycle 2, rsp_valid width 4, correct 64-bit data.

Source files
------------

// File: rtl/bram_pipe_ctrl.sv
// Fixed-latency BRAM controller: requests from NCH channels travel a LAT-stage
// pipeline, access the array at the last stage and respond to their channel.
module bram_pipe_ctrl #(
   parameter int unsigned AW  = 13,
   parameter int unsigned DW  = 32,
   parameter int unsigned LAT = 10,
   parameter int unsigned NCH = 2,
   localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int unsigned IW = $clog2(LAT + 1),
   localparam int unsigned NB = DW / 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   input  logic           req_we,
   input  logic [AW-1:0]  req_addr,
   input  logic [DW-1:0]  req_wdata,
   input  logic [NB-1:0]  req_wstrb,
   input  logic [CW-1:0]  req_ch,
   output logic [NCH-1:0] rsp_valid,
   output logic           rsp_we,
   output logic [DW-1:0]  rsp_rdata,
   output logic           rsp_err,
   output logic [IW-1:0]  inflight
);
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned LAST  = LAT - 1;

   logic [LAT-1:0] st_valid;
   logic           st_we    [LAT];
   logic [AW-1:0]  st_addr  [LAT];
   logic [DW-1:0]  st_wdata [LAT];
   logic [NB-1:0]  st_wstrb [LAT];
   logic [CW-1:0]  st_ch    [LAT];

   logic [DW-1:0]  mem [DEPTH];

   logic           last_v_c;
   logic           ch_ok_c;
   logic           acc_c;
   logic [NCH-1:0] onehot_c;

   // Stage valids are the only pipeline state that reset must clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_valid <= '0;
      end else begin
         st_valid <= {st_valid[LAT-2:0], req_valid};
      end
   end

   always_ff @(posedge clk) begin
      st_we[0]    <= req_we;
      st_addr[0]  <= req_addr;
      st_wdata[0] <= req_wdata;
      st_wstrb[0] <= req_wstrb;
      st_ch[0]    <= req_ch;
      for (int i = 1; i < int'(LAT); i++) begin
         st_we[i]    <= st_we[i-1];
         st_addr[i]  <= st_addr[i-1];
         st_wdata[i] <= st_wdata[i-1];
         st_wstrb[i] <= st_wstrb[i-1];
         st_ch[i]    <= st_ch[i-1];
      end
   end

   // Last-stage decode: channel range check and one-hot routing
   always_comb begin
      last_v_c = st_valid[LAST];
      ch_ok_c  = ({1'b0, st_ch[LAST]} < (CW + 1)'(NCH));
      acc_c    = last_v_c & ch_ok_c;
      onehot_c = '0;
      for (int c = 0; c < int'(NCH); c++) begin
         if (st_ch[LAST] == CW'(c)) begin
            onehot_c[c] = acc_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc_c && st_we[LAST]) begin
         for (int b = 0; b < int'(NB); b++) begin
            if (st_wstrb[LAST][b]) begin
               mem[st_addr[LAST]][8*b +: 8] <= st_wdata[LAST][8*b +: 8];
            end
         end
      end
   end

   // Responses leave the access stage; rdata only moves on a real read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_we    <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         inflight  <= '0;
      end else begin
         rsp_valid <= onehot_c;
         rsp_we    <= last_v_c & st_we[LAST];
         rsp_err   <= last_v_c & ~ch_ok_c;
         if (acc_c && !st_we[LAST]) begin
            rsp_rdata <= mem[st_addr[LAST]];
         end
         inflight  <= inflight + IW'(req_valid) - IW'(last_v_c);
      end
   end
endmodule

// File: tb/tb_bram_pipe_ctrl.sv
// Bench for bram_pipe_ctrl: three configurations, checked cycle by cycle
// against an in-order request/response memory model.
module tb_bram_pipe_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [12:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic [1:0]  req_ch;
   int          sel;

   always #5 clk = ~clk;

   logic [1:0]  v0; logic we0; logic [31:0] d0; logic e0; logic [3:0] f0;
   logic [2:0]  v1; logic we1; logic [31:0] d1; logic e1; logic [3:0] f1;
   logic [3:0]  v2; logic we2; logic [63:0] d2; logic e2; logic [1:0] f2;

   bram_pipe_ctrl #(.AW(13), .DW(32), .LAT(10), .NCH(2)) u_d0 (
      .clk(clk), .rst(rst), .req_valid(req_valid && sel == 0), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_wstrb(req_wstrb[3:0]),
      .req_ch(req_ch[0:0]), .rsp_valid(v0), .rsp_we(we0), .rsp_rdata(d0),
      .rsp_err(e0), .inflight(f0));

   bram_pipe_ctrl #(.AW(13), .DW(32), .LAT(10), .NCH(3)) u_d1 (
      .clk(clk), .rst(rst), .req_valid(req_valid && sel == 1), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_wstrb(req_wstrb[3:0]),
      .req_ch(req_ch), .rsp_valid(v1), .rsp_we(we1), .rsp_rdata(d1),
      .rsp_err(e1), .inflight(f1));

   bram_pipe_ctrl #(.AW(13), .DW(64), .LAT(2), .NCH(4)) u_d2 (
      .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .req_ch(req_ch), .rsp_valid(v2), .rsp_we(we2), .rsp_rdata(d2),
      .rsp_err(e2), .inflight(f2));

   logic [3:0]  ov;
   logic        owe, oerr;
   logic [63:0] ord;
   int          oinf;

   always_comb begin
      ov = '0; owe = 1'b0; oerr = 1'b0; ord = '0; oinf = 0;
      case (sel)
         0: begin ov = {2'b00, v0}; owe = we0; oerr = e0; ord = {32'h0, d0}; oinf = int'(f0); end
         1: begin ov = {1'b0, v1};  owe = we1; oerr = e1; ord = {32'h0, d1}; oinf = int'(f1); end
         default: begin ov = v2;    owe = we2; oerr = e2; ord = d2;          oinf = int'(f2); end
      endcase
   end

   typedef struct {
      int          due;
      logic        we;
      logic [12:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      int          ch;
   } req_t;

   req_t        pend[$];
   logic [63:0] mem_m   [int];
   logic [7:0]  known_m [int];
   logic [63:0] last_rd;
   logic [7:0]  last_mask;
   int          cyc, nvec, nerr, peak, nrsp;

   function automatic int lat_of(input int s);  return (s == 2) ? 2 : 10; endfunction
   function automatic int nch_of(input int s);  return s + 2;             endfunction
   function automatic int nb_of(input int s);   return (s == 2) ? 8 : 4;  endfunction

   function automatic logic [63:0] bmask(input logic [7:0] m);
      logic [63:0] r;
      for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s cyc=%0d obs=%h exp=%h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: model executes whatever request is due, then compares outputs
   task automatic step();
      req_t        r;
      logic [3:0]  ev;
      logic        ewe, eerr;
      logic [63:0] w;
      logic [7:0]  k;
      int          key;
      @(posedge clk);
      cyc++;
      if (req_valid && !rst) begin
         r.due = cyc + lat_of(sel); r.we = req_we; r.addr = req_addr;
         r.wdata = req_wdata; r.wstrb = req_wstrb; r.ch = int'(req_ch);
         pend.push_back(r);
      end
      #1;
      ev = '0; ewe = 1'b0; eerr = 1'b0;
      if (rst) begin
         pend.delete();
         last_rd = '0; last_mask = 8'hFF;
      end else if (pend.size() > 0 && pend[0].due == cyc) begin
         r   = pend.pop_front();
         key = sel * 8192 + int'(r.addr);
         ewe = r.we;
         if (r.ch >= nch_of(sel)) begin
            eerr = 1'b1;
         end else begin
            ev[r.ch] = 1'b1;
            w = mem_m.exists(key) ? mem_m[key] : 64'h0;
            k = known_m.exists(key) ? known_m[key] : 8'h00;
            if (r.we) begin
               for (int b = 0; b < nb_of(sel); b++) begin
                  if (r.wstrb[b]) begin w[8*b +: 8] = r.wdata[8*b +: 8]; k[b] = 1'b1; end
               end
               mem_m[key] = w; known_m[key] = k;
            end else begin
               last_rd = w; last_mask = k;
            end
         end
      end
      if (ov != 0) nrsp++;
      if (oinf > peak) peak = oinf;
      check("rsp_valid", 64'(ov), 64'(ev));
      check("rsp_err", 64'(oerr), 64'(eerr));
      if (ev != 0) check("rsp_we", 64'(owe), 64'(ewe));
      check("rsp_rdata", ord & bmask(last_mask), last_rd & bmask(last_mask));
      check("inflight", 64'(oinf), 64'(pend.size()));
   endtask

   task automatic issue(input logic we, input logic [12:0] a, input logic [63:0] d,
                        input logic [7:0] s, input int ch);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
      req_ch = 2'(ch);
      step();
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      idle(n);
      rst = 1'b0;
   endtask

   task automatic preload(input int n);
      for (int a = 0; a < n; a++) issue(1'b1, 13'(a), {$urandom, $urandom}, 8'hFF, 0);
   endtask

   task automatic random_mix(input int n, input int maxch);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) != 0)
            issue(1'($urandom), 13'($urandom_range(0, 15)), {$urandom, $urandom},
                  8'($urandom), int'($urandom_range(0, maxch)));
         else
            step();
      end
   endtask

   initial begin
      cyc = 0; nvec = 0; nerr = 0; peak = 0; nrsp = 0;
      last_rd = '0; last_mask = 8'hFF;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_wstrb = '0; req_ch = '0; sel = 0; rst = 1'b1;

      // Default configuration: LAT=10, NCH=2, DW=32
      do_reset(3);
      issue(1'b1, 13'h005, 64'hDEADBEEF, 8'hF, 0);
      issue(1'b0, 13'h005, 64'h0, 8'h0, 1);
      idle(12);

      issue(1'b1, 13'h1FFF, 64'h11223344, 8'hF, 0);
      issue(1'b1, 13'h1FFF, 64'h000000AA, 8'h1, 1);
      issue(1'b0, 13'h1FFF, 64'h0, 8'h0, 0);
      issue(1'b1, 13'h1FFF, 64'hFFFFFFFF, 8'h0, 1);
      issue(1'b0, 13'h1FFF, 64'h0, 8'h0, 1);
      idle(12);

      preload(16);
      idle(12);
      peak = 0; nrsp = 0;
      for (int i = 0; i < 20; i++) issue(1'b0, 13'($urandom_range(0, 15)), 64'h0, 8'h0, i % 2);
      idle(12);
      check("stream_peak", 64'(peak), 64'd10);
      check("stream_rsps", 64'(nrsp), 64'd20);

      random_mix(200, 1);
      idle(12);

      // Writes discarded by a reset before they reach the array
      for (int i = 0; i < 5; i++) issue(1'b1, 13'(i), {$urandom, $urandom}, 8'hF, i % 2);
      idle(3);
      do_reset(2);
      idle(12);
      for (int i = 0; i < 5; i++) issue(1'b0, 13'(i), 64'h0, 8'h0, i % 2);
      idle(12);

      // NCH=3: channel 3 is out of range
      sel = 1;
      do_reset(2);
      issue(1'b1, 13'h007, 64'hCAFEF00D, 8'hF, 2);
      issue(1'b1, 13'h007, 64'h12345678, 8'hF, 3);
      issue(1'b0, 13'h007, 64'h0, 8'h0, 3);
      issue(1'b0, 13'h007, 64'h0, 8'h0, 0);
      idle(12);
      preload(16);
      random_mix(150, 3);
      idle(12);

      // LAT=2, NCH=4, DW=64
      sel = 2;
      do_reset(2);
      issue(1'b1, 13'h005, 64'hDEADBEEF_0BADF00D, 8'hFF, 0);
      issue(1'b0, 13'h005, 64'h0, 8'h0, 1);
      idle(4);
      preload(16);
      random_mix(200, 3);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
